// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC encoder controller: register offsets,
// codeword width encodings, result masks and the sequencing FSM states.
package ecc_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_DATA   = 3'd1;
    localparam logic [2:0] OFF_WIDTH  = 3'd2;
    localparam logic [2:0] OFF_RESULT = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    localparam logic [1:0] CW_SMALL   = 2'b00;
    localparam logic [1:0] CW_MEDIUM  = 2'b01;
    localparam logic [1:0] CW_LARGE   = 2'b10;
    localparam logic [1:0] CW_ILLEGAL = 2'b11;

    localparam logic [31:0] MASK_SMALL  = 32'h0000_00FF;
    localparam logic [31:0] MASK_MEDIUM = 32'h0000_FFFF;
    localparam logic [31:0] MASK_LARGE  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // An illegal width yields an all-zero mask; it never reaches the capture path.
    function automatic logic [31:0] cw_mask(input logic [1:0] width);
        case (width)
            CW_SMALL:  return MASK_SMALL;
            CW_MEDIUM: return MASK_MEDIUM;
            CW_LARGE:  return MASK_LARGE;
            default:   return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/ecc_enc_ctrl_if.sv
// APB bus bundle between a host master and the ECC encoder controller.
interface ecc_enc_ctrl_if #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
);

    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/ecc_apb_regs.sv
// APB decode, register file and error response for the ECC encoder controller.
// Issues a start strobe to the sequencer and holds RESULT/STATUS for software.
module ecc_apb_regs
    import ecc_pkg::*;
#(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ecc_enc_ctrl_if.slave        apb,
    input  logic                 busy,
    input  logic                 op_done,
    input  logic                 result_load,
    input  logic [AMBA_WORD-1:0] result_value,
    output logic                 start,
    output logic [AMBA_WORD-1:0] data_in,
    output logic [1:0]           cw_width
);

    logic                 access;
    logic [2:0]           offset;
    logic                 mapped;
    logic                 wr_ro;
    logic                 wr_busy;
    logic                 err;
    logic                 wr_ok;
    logic [AMBA_WORD-1:0] rdata;
    logic [AMBA_WORD-1:0] result_q;
    logic                 done_sticky;
    logic                 cfg_err;
    logic                 unused_addr_bits;

    assign access = apb.PSEL & apb.PENABLE;
    assign offset = apb.PADDR[4:2];
    assign unused_addr_bits = ^{apb.PADDR[AMBA_ADDR_WIDTH-1:5], apb.PADDR[1:0]};

    // Rejected writes are flagged here and never reach the register file.
    always_comb begin
        mapped  = (offset <= OFF_STATUS);
        wr_ro   = (offset == OFF_RESULT) || (offset == OFF_STATUS);
        wr_busy = busy && ((offset == OFF_CTRL) || (offset == OFF_DATA) ||
                           (offset == OFF_WIDTH));
        err     = access && (!mapped || (apb.PWRITE && (wr_ro || wr_busy)));
        wr_ok   = access && apb.PWRITE && !err;
    end

    assign start = wr_ok && (offset == OFF_CTRL) &&
                   (apb.PWDATA == {{(AMBA_WORD-1){1'b0}}, 1'b1});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_in     <= '0;
            cw_width    <= 2'b00;
            result_q    <= '0;
            done_sticky <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (wr_ok && (offset == OFF_DATA)) begin
                data_in <= apb.PWDATA;
            end
            if (wr_ok && (offset == OFF_WIDTH)) begin
                cw_width <= apb.PWDATA[1:0];
            end
            if (result_load) begin
                result_q <= result_value;
            end
            if (start) begin
                done_sticky <= 1'b0;
                cfg_err     <= (cw_width == CW_ILLEGAL);
            end else if (op_done) begin
                done_sticky <= 1'b1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (access && !apb.PWRITE) begin
            case (offset)
                OFF_DATA:   rdata = data_in;
                OFF_WIDTH:  rdata = AMBA_WORD'(cw_width);
                OFF_RESULT: rdata = result_q;
                OFF_STATUS: rdata = AMBA_WORD'({cfg_err, done_sticky, busy});
                default:    rdata = '0;
            endcase
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = err;

endmodule

// File: rtl/ecc_enc_ctrl.sv
// ECC encoder controller: APB register file plus a sequencer that drives the
// external registered encoder and captures its width-masked codeword.
module ecc_enc_ctrl
    import ecc_pkg::*;
#(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ecc_enc_ctrl_if.slave        apb,
    output logic                 enc_small,
    output logic                 enc_medium,
    output logic                 enc_large,
    output logic [AMBA_WORD-1:0] enc_data,
    output logic [1:0]           enc_cw_width,
    input  logic [AMBA_WORD-1:0] enc_out,
    output logic                 operation_done,
    output logic                 busy
);

    state_t                state_q;
    state_t                state_d;
    logic                  start;
    logic                  legal_start;
    logic                  result_load;
    logic [AMBA_WORD-1:0]  data_in;
    logic [1:0]            cw_width;
    logic [DATA_WIDTH-1:0] masked_cw;
    logic [AMBA_WORD-1:0]  result_value;

    ecc_apb_regs #(
        .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH),
        .AMBA_WORD       (AMBA_WORD)
    ) u_regs (
        .clk          (clk),
        .rst          (rst),
        .apb          (apb),
        .busy         (busy),
        .op_done      (operation_done),
        .result_load  (result_load),
        .result_value (result_value),
        .start        (start),
        .data_in      (data_in),
        .cw_width     (cw_width)
    );

    assign legal_start = start && (cw_width != CW_ILLEGAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An illegal width skips the encoder entirely and reports completion at once.
    always_comb begin
        state_d        = state_q;
        result_load    = 1'b0;
        operation_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (cw_width == CW_ILLEGAL) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d     = ST_DONE;
                result_load = 1'b1;
            end
            ST_DONE: begin
                state_d        = ST_IDLE;
                operation_done = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    // Encoder inputs only change on a legal start, so they hold between operations.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_data     <= '0;
            enc_cw_width <= 2'b00;
            enc_small    <= 1'b0;
            enc_medium   <= 1'b0;
            enc_large    <= 1'b0;
        end else if (legal_start) begin
            enc_data     <= data_in;
            enc_cw_width <= cw_width;
            enc_small    <= (cw_width == CW_SMALL);
            enc_medium   <= (cw_width == CW_MEDIUM);
            enc_large    <= (cw_width == CW_LARGE);
        end
    end

    assign masked_cw    = DATA_WIDTH'(enc_out) & DATA_WIDTH'(cw_mask(enc_cw_width));
    assign result_value = AMBA_WORD'(masked_cw);

endmodule

// File: tb/tb_ecc_enc_ctrl.sv
// Self-checking bench for ecc_enc_ctrl: a stand-in registered encoder, a
// vector table, hand-written corner sequences and randomized operations.
module tb_ecc_enc_ctrl;

    localparam logic [19:0] A_CTRL   = 20'h00000;
    localparam logic [19:0] A_DATA   = 20'h00004;
    localparam logic [19:0] A_WIDTH  = 20'h00008;
    localparam logic [19:0] A_RESULT = 20'h0000C;
    localparam logic [19:0] A_STATUS = 20'h00010;
    localparam logic [19:0] A_BAD    = 20'h00014;
    localparam logic [19:0] A_BAD2   = 20'h0001C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enc_small, enc_medium, enc_large;
    logic [31:0] enc_data;
    logic [1:0]  enc_cw_width;
    logic [31:0] enc_out;
    logic        operation_done;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_access_cyc = 0;
    int done_q[$];

    always #5 clk = ~clk;

    ecc_enc_ctrl_if #(.AMBA_ADDR_WIDTH(20), .AMBA_WORD(32)) apb ();

    ecc_enc_ctrl #(
        .AMBA_ADDR_WIDTH (20),
        .AMBA_WORD       (32),
        .DATA_WIDTH      (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .apb            (apb),
        .enc_small      (enc_small),
        .enc_medium     (enc_medium),
        .enc_large      (enc_large),
        .enc_data       (enc_data),
        .enc_cw_width   (enc_cw_width),
        .enc_out        (enc_out),
        .operation_done (operation_done),
        .busy           (busy)
    );

    // Toy extended-Hamming encoder: the data nibbles covered by the width are
    // folded into one nibble whose 4 check bits replace OUT[3:0].
    function automatic logic [31:0] enc_model(input logic [31:0] d, input logic [1:0] w);
        logic [3:0] x;
        logic [3:0] p;
        int groups;
        groups = (w == 2'd0) ? 1 : (w == 2'd1) ? 3 : 7;
        x = 4'h0;
        for (int g = 1; g <= groups; g++) x ^= d[g*4 +: 4];
        p[0] = x[0] ^ x[1] ^ x[3];
        p[1] = x[0] ^ x[2] ^ x[3];
        p[2] = x[1] ^ x[2] ^ x[3];
        p[3] = ^{x, p[2:0]};
        return {d[31:4], p};
    endfunction

    function automatic logic [31:0] exp_result(input logic [31:0] d, input logic [1:0] w);
        logic [63:0] full;
        int bits;
        bits = 8 << w;
        full = {32'h0, enc_model(d, w)};
        return 32'(full % (64'd1 << bits));
    endfunction

    always @(posedge clk) enc_out <= enc_model(enc_data, enc_cw_width);
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (operation_done === 1'b1) done_q.push_back(cyc);

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [19:0] addr, input logic [31:0] data, output logic err);
        apb.PADDR   = addr;
        apb.PWDATA  = data;
        apb.PWRITE  = 1'b1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        last_access_cyc = cyc;
        #3;
        err = apb.PSLVERR;
        @(posedge clk); #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] addr, output logic [31:0] data, output logic err);
        apb.PADDR   = addr;
        apb.PWRITE  = 1'b0;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        #3;
        check_output("prdata_setup_phase", apb.PRDATA, 32'h0);
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        #3;
        data = apb.PRDATA;
        err  = apb.PSLVERR;
        @(posedge clk); #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [31:0] d, input logic [1:0] w, output int start_c);
        logic err;
        apb_write(A_DATA, d, err);
        apb_write(A_WIDTH, {30'b0, w}, err);
        done_q.delete();
        apb_write(A_CTRL, 32'h1, err);
        start_c = last_access_cyc;
    endtask

    task automatic wait_done(input string tag, input int start_c, input int exp_lat);
        for (int i = 0; i < 12 && done_q.size() == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check_output({tag, "_done_count"}, done_q.size(), 1);
        check_output({tag, "_latency"}, (done_q.size() > 0) ? done_q[0] - start_c : -1, exp_lat);
    endtask

    // Full operation; for legal widths the selects are checked in DRIVE and CAPTURE.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [1:0] w);
        int start_c;
        logic [31:0] sel_exp;
        sel_exp = {29'b0, w == 2'd0, w == 2'd1, w == 2'd2};
        apply_stimulus(d, w, start_c);
        if (w != 2'd3) begin
            check_output({tag, "_sel_drive"}, {29'b0, enc_small, enc_medium, enc_large}, sel_exp);
            @(posedge clk); #1;
            check_output({tag, "_sel_capture"}, {29'b0, enc_small, enc_medium, enc_large}, sel_exp);
            check_output({tag, "_busy"}, {31'b0, busy}, 32'h1);
        end
        wait_done(tag, start_c, (w == 2'd3) ? 1 : 3);
    endtask

    typedef struct {
        logic [31:0] data;
        logic [1:0]  width;
        logic [31:0] exp_result;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] rd;
        logic        err;
        int          s;
        logic [31:0] d;
        logic [1:0]  w;

        vecs[0] = '{32'h0000_00F0, 2'd0, 32'h0000_00FF, 32'h2};
        vecs[1] = '{32'h0000_0000, 2'd2, 32'h0000_0000, 32'h2};
        vecs[2] = '{32'h1234_5670, 2'd1, 32'h0000_567E, 32'h2};
        vecs[3] = '{32'hABCD_0000, 2'd3, 32'h0000_567E, 32'h6};
        vecs[4] = '{32'h0000_00A0, 2'd0, 32'h0000_00AA, 32'h2};
        vecs[5] = '{32'hFFFF_FFFF, 2'd2, 32'hFFFF_FFFF, 32'h2};
        vecs[6] = '{32'hFFFF_FFFF, 2'd0, 32'h0000_00FF, 32'h2};

        apb.PADDR = '0; apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        apb.PWRITE = 1'b0; apb.PWDATA = '0;

        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy", {31'b0, busy}, 32'h0);
        check_output("rst_done", {31'b0, operation_done}, 32'h0);
        check_output("rst_sel", {29'b0, enc_small, enc_medium, enc_large}, 32'h0);
        check_output("rst_enc_data", enc_data, 32'h0);
        check_output("rst_pslverr", {31'b0, apb.PSLVERR}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i <= 4; i++) begin
            apb_read(20'(i * 4), rd, err);
            check_output($sformatf("reset_read_%0d", i), rd, 32'h0);
            check_output($sformatf("reset_err_%0d", i), {31'b0, err}, 32'h0);
        end
        apb_read(A_BAD, rd, err);
        check_output("unmapped_read_err", {31'b0, err}, 32'h1);

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].width);
            apb_read(A_RESULT, rd, err);
            check_output($sformatf("vec%0d_result", i), rd, vecs[i].exp_result);
            apb_read(A_STATUS, rd, err);
            check_output($sformatf("vec%0d_status", i), rd, vecs[i].exp_status);
        end

        // Write while busy is rejected and leaves DATA_IN and the result intact.
        apply_stimulus(32'h0000_0011, 2'd0, s);
        apb_write(A_DATA, 32'h0000_0022, err);
        check_output("busy_write_err", {31'b0, err}, 32'h1);
        wait_done("busy_write", s, 3);
        apb_read(A_DATA, rd, err);
        check_output("busy_write_data", rd, 32'h0000_0011);
        apb_read(A_RESULT, rd, err);
        check_output("busy_write_result", rd, exp_result(32'h0000_0011, 2'd0));

        apb_write(A_RESULT, 32'hDEAD_BEEF, err);
        check_output("ro_result_err", {31'b0, err}, 32'h1);
        apb_write(A_STATUS, 32'h7, err);
        check_output("ro_status_err", {31'b0, err}, 32'h1);
        apb_write(A_BAD2, 32'h1, err);
        check_output("unmapped_write_err", {31'b0, err}, 32'h1);
        apb_read(A_RESULT, rd, err);
        check_output("ro_result_kept", rd, exp_result(32'h0000_0011, 2'd0));
        done_q.delete();
        apb_write(A_CTRL, 32'h2, err);
        check_output("ctrl_nonone_err", {31'b0, err}, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check_output("ctrl_nonone_no_done", done_q.size(), 0);
        check_output("ctrl_nonone_idle", {31'b0, busy}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            w = 2'($urandom_range(0, 2));
            run_op($sformatf("rand%0d", i), d, w);
            apb_read(A_RESULT, rd, err);
            check_output($sformatf("rand%0d_result", i), rd, exp_result(d, w));
        end

        // Reset during CAPTURE aborts the operation without a result or done pulse.
        apply_stimulus(32'h5A5A_5A5A, 2'd2, s);
        @(posedge clk); #1;
        check_output("abort_busy_before", {31'b0, busy}, 32'h1);
        rst = 1'b0;
        #2;
        check_output("abort_busy_now", {31'b0, busy}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("abort_no_done", done_q.size(), 0);
        apb_read(A_RESULT, rd, err);
        check_output("abort_result", rd, 32'h0);
        apb_read(A_STATUS, rd, err);
        check_output("abort_status", rd, 32'h0);
        apb_read(A_DATA, rd, err);
        check_output("abort_data", rd, 32'h0);
        run_op("after_abort", 32'h0000_BEE0, 2'd1);
        apb_read(A_RESULT, rd, err);
        check_output("after_abort_result", rd, exp_result(32'h0000_BEE0, 2'd1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
